// File: rtl/ft_resp_pkg.sv
// ft_resp_pkg: shared widths, constants and read-FSM states for the FT FIFO responder.
package ft_resp_pkg;
  localparam int DATA_W = 16;
  localparam int BE_W = 2;
  localparam int BURST_CNT_W = 9;
  localparam logic [BE_W-1:0] BE_ALL = 2'b11;
  typedef enum logic [1:0] {RD_IDLE, RD_DRIVE, RD_POP} rd_state_e;
endpackage

// File: rtl/ft_fifo_responder_if.sv
// ft_fifo_responder_if: host stream + FT bus bundle; FT_FIFO_RESPONDER_BURST_CHECK_EN adds burst_len_err.
interface ft_fifo_responder_if import ft_resp_pkg::*; ();
  logic cmd_valid, cmd_ready, cap_valid, cap_ready;
  logic ft_rxf_n, ft_txe_n, ft_oe_n, ft_rd_n, ft_wr_n, ft_oe;
  logic burst_done, proto_err;
  logic [DATA_W-1:0] cmd_data, cap_data, ft_data_i, ft_data_o;
  logic [BE_W-1:0] cap_be, ft_be_i, ft_be_o;
  logic [BURST_CNT_W-1:0] burst_len;
`ifdef FT_FIFO_RESPONDER_BURST_CHECK_EN
  logic burst_len_err;
`endif
  modport slave (
    input cmd_valid, cmd_data, cap_ready, ft_oe_n, ft_rd_n, ft_wr_n, ft_data_i, ft_be_i,
    output cmd_ready, cap_valid, cap_data, cap_be, ft_rxf_n, ft_txe_n, ft_data_o, ft_be_o,
    output ft_oe, burst_done, burst_len, proto_err
`ifdef FT_FIFO_RESPONDER_BURST_CHECK_EN
    , output burst_len_err
`endif
  );
  modport master (
    output cmd_valid, cmd_data, cap_ready, ft_oe_n, ft_rd_n, ft_wr_n, ft_data_i, ft_be_i,
    input cmd_ready, cap_valid, cap_data, cap_be, ft_rxf_n, ft_txe_n, ft_data_o, ft_be_o,
    input ft_oe, burst_done, burst_len, proto_err
`ifdef FT_FIFO_RESPONDER_BURST_CHECK_EN
    , input burst_len_err
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    count = wr_q - rd_q;
    full = count == (AW+1)'(DEPTH);
    empty = wr_q == rd_q;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    wr_q <= reset ? '0 : wr_d;
    rd_q <= reset ? '0 : rd_d;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/ft_fifo_responder.sv
// ft_fifo_responder: device side of the 16-bit synchronous FT FIFO bus with host command/capture streams.
// Define FT_FIFO_RESPONDER_BURST_CHECK_EN to flag bursts whose length differs from EXP_BURST.
module ft_fifo_responder import ft_resp_pkg::*; #(
  parameter int CMD_DEPTH = 8,
  parameter int CAP_DEPTH = 512,
  parameter int EXP_BURST = 256
) (
  input logic clk,
  input logic reset,
  ft_fifo_responder_if.slave bus
);
  localparam int CMW = $clog2(CMD_DEPTH) + 1;
  localparam int CPW = $clog2(CAP_DEPTH) + 1;
  localparam int CAP_W = BE_W + DATA_W;
  if ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || CMD_DEPTH < 2 || (CAP_DEPTH & (CAP_DEPTH - 1)) != 0 ||
      CAP_DEPTH < 2 || EXP_BURST < 1 || EXP_BURST > 511) begin : g_bad_param
    $error("ft_fifo_responder: illegal parameter value");
  end
  rd_state_e state_q, state_d;
  logic cmd_push, cmd_pop, cmd_full, cmd_empty, cap_push, cap_pop, cap_full, cap_empty;
  logic [DATA_W-1:0] cmd_head;
  logic [CAP_W-1:0] cap_head;
  logic [CMW-1:0] cmd_count;
  logic [CPW-1:0] cap_count;
  logic rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, oe_q, oe_d, wr_n_prev_q;
  logic burst_done_q, burst_done_d, proto_err_q, proto_err_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d, burst_len_q, burst_len_d;
  logic rd_strobe, rd_err, wr_req, contention, burst_end, len_err;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk), .reset(reset), .push(cmd_push), .pop(cmd_pop), .din(bus.cmd_data),
    .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count));
  sync_fifo #(.WIDTH(CAP_W), .DEPTH(CAP_DEPTH)) u_cap (
    .clk(clk), .reset(reset), .push(cap_push), .pop(cap_pop), .din({bus.ft_be_i, bus.ft_data_i}),
    .dout(cap_head), .full(cap_full), .empty(cap_empty), .count(cap_count));
  always_ff @(posedge clk)
    state_q <= reset ? RD_IDLE : state_d;
  // RD_POP marks a cycle that consumed a word; both driving states keep streaming while RD_N stays low
  always_comb
    state_d = bus.ft_oe_n ? RD_IDLE : (state_q == RD_IDLE || bus.ft_rd_n) ? RD_DRIVE : RD_POP;
  always_comb begin
    rd_strobe = state_q != RD_IDLE && !bus.ft_oe_n && !bus.ft_rd_n;
    cmd_pop = rd_strobe && !cmd_empty;
    rd_err = rd_strobe && cmd_empty;
    oe_d = state_d != RD_IDLE && bus.ft_wr_n;
  end
`ifdef FT_FIFO_RESPONDER_BURST_CHECK_EN
  logic burst_len_err_q, burst_len_err_d;
  assign len_err = burst_end && cnt_q != BURST_CNT_W'(EXP_BURST);
  assign burst_len_err_d = burst_len_err_q || len_err;
  always_ff @(posedge clk)
    burst_len_err_q <= reset ? 1'b0 : burst_len_err_d;
  assign bus.burst_len_err = burst_len_err_q;
`else
  assign len_err = 1'b0;
`endif
  always_comb begin
    contention = !bus.ft_oe_n && !bus.ft_wr_n;
    wr_req = !bus.ft_wr_n && bus.ft_oe_n;
    cmd_push = bus.cmd_valid && !cmd_full;
    cap_push = wr_req && !cap_full;
    cap_pop = !cap_empty && bus.cap_ready;
    burst_end = bus.ft_wr_n && !wr_n_prev_q;
    rxf_n_d = cmd_count + CMW'(cmd_push) - CMW'(cmd_pop) == '0;
    txe_n_d = cap_count + CPW'(cap_push) - CPW'(cap_pop) >= CPW'(CAP_DEPTH - 1);
    cnt_d = burst_end ? '0 : (cap_push && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    burst_done_d = burst_end;
    burst_len_d = burst_end ? cnt_q : burst_len_q;
    proto_err_d = proto_err_q || rd_err || contention || (wr_req && cap_full) || len_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_n_q <= 1'b1;
      txe_n_q <= 1'b1;
      oe_q <= 1'b0;
      wr_n_prev_q <= 1'b1;
      cnt_q <= '0;
      burst_done_q <= 1'b0;
      burst_len_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rxf_n_q <= rxf_n_d;
      txe_n_q <= txe_n_d;
      oe_q <= oe_d;
      wr_n_prev_q <= bus.ft_wr_n;
      cnt_q <= cnt_d;
      burst_done_q <= burst_done_d;
      burst_len_q <= burst_len_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign bus.cmd_ready = !cmd_full;
  assign bus.cap_valid = !cap_empty;
  assign {bus.cap_be, bus.cap_data} = cap_empty ? '0 : cap_head;
  assign bus.ft_rxf_n = rxf_n_q;
  assign bus.ft_txe_n = txe_n_q;
  assign bus.ft_oe = oe_q && !contention;
  assign bus.ft_data_o = (oe_q && !cmd_empty) ? cmd_head : '0;
  assign bus.ft_be_o = oe_q ? BE_ALL : '0;
  assign bus.burst_done = burst_done_q;
  assign bus.burst_len = burst_len_q;
  assign bus.proto_err = proto_err_q;
endmodule
